// File: rtl/line_mem_responder.sv
// line_mem_responder: single-outstanding line memory responder with fixed latencies.
//
// Stores LINE_NUMS 128-bit lines. A request handshakes in IDLE only; reads return
// the addressed line RD_LATENCY cycles after the handshake and hold it until
// res_ready. Writes are committed WR_LATENCY cycles after the handshake, in the
// same cycle as a one-cycle axi_Wdone = 2'b01 pulse.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   req_valid  in   request valid
//   req_ready  out  request accepted this cycle (high only in IDLE)
//   req_addr   in   byte address of the line; bits [3:0] ignored, high bits alias
//   write_en   in   1 = write-back, 0 = line fill read
//   req_Wdata  in   write-back line data
//   res_valid  out  read data valid
//   res_ready  in   initiator accepts read data
//   res_Rdata  out  read line data (holds last value while res_valid = 0)
//   axi_Wdone  out  2'b01 for one cycle on write completion, else 2'b00

module line_mem_responder #(
    parameter int unsigned LINE_NUMS  = 256,
    parameter int unsigned RD_LATENCY = 4,
    parameter int unsigned WR_LATENCY = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [31:0]  req_addr,
    input  logic         write_en,
    input  logic [127:0] req_Wdata,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [127:0] res_Rdata,
    output logic [1:0]   axi_Wdone
);

    localparam int unsigned IdxW   = $clog2(LINE_NUMS);
    localparam int unsigned MaxLat = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int unsigned CntW   = (MaxLat > 1) ? $clog2(MaxLat) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StRdWait,
        StRdResp,
        StWrWait,
        StWrDone
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [127:0]      wdata_q, wdata_d;
    logic [127:0]      rdata_q, rdata_d;

    // Storage is deliberately left uninitialised.
    logic [127:0]      mem_q [LINE_NUMS];

    // Address bits outside the line index are don't-care.
    logic unused_addr;
    assign unused_addr = ^{req_addr[31:4+IdxW], req_addr[3:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    idx_d = req_addr[4+IdxW-1:4];
                    if (write_en) begin
                        wdata_d = req_Wdata;
                        cnt_d   = CntW'(WR_LATENCY - 1);
                        state_d = StWrWait;
                    end else begin
                        cnt_d   = CntW'(RD_LATENCY - 1);
                        state_d = StRdWait;
                    end
                end
            end
            StRdWait: begin
                if (cnt_q == '0) begin
                    // No write can land between handshake and here, so this is
                    // the line as it stood at the handshake.
                    rdata_d = mem_q[idx_q];
                    state_d = StRdResp;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StRdResp: begin
                if (res_ready) begin
                    state_d = StIdle;
                end
            end
            StWrWait: begin
                if (cnt_q == '0) begin
                    state_d = StWrDone;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StWrDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Commit happens on the edge that ends WR_DONE, i.e. once the pulse is out.
    always_ff @(posedge clk) begin
        if (state_q == StWrDone) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign req_ready = (state_q == StIdle);
    assign res_valid = (state_q == StRdResp);
    assign res_Rdata = rdata_q;
    assign axi_Wdone = (state_q == StWrDone) ? 2'b01 : 2'b00;

endmodule

// File: tb/tb_line_mem_responder.sv
module tb_line_mem_responder;

    localparam int unsigned LINES = 256;
    localparam int unsigned RD    = 4;
    localparam int unsigned WR    = 2;
    localparam logic [127:0] DB   = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [31:0]  req_addr = '0;
    logic         write_en = 1'b0;
    logic [127:0] req_Wdata = '0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [127:0] res_Rdata;
    logic [1:0]   axi_Wdone;

    int checks   = 0;
    int failures = 0;

    // Reference model: plain array of lines indexed by (addr / 16) mod LINES.
    logic [127:0] model_mem [LINES];
    bit           written   [LINES];

    typedef struct {
        bit           wr;
        logic [31:0]  addr;
        logic [127:0] data;  // write data, or expected read data
        int unsigned  hold;  // cycles res_ready is held low after res_valid
    } vec_t;

    vec_t vecs[$];

    line_mem_responder #(
        .LINE_NUMS (LINES),
        .RD_LATENCY(RD),
        .WR_LATENCY(WR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .write_en (write_en),
        .req_Wdata(req_Wdata),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_Rdata(res_Rdata),
        .axi_Wdone(axi_Wdone)
    );

    always #5 clk = ~clk;

    function automatic int unsigned line_of(logic [31:0] a);
        return (a >> 4) % LINES;
    endfunction

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request and wait (bounded) for the handshake edge; returns just after it.
    task automatic handshake(bit wr, logic [31:0] addr, logic [127:0] data);
        int n = 0;
        req_valid = 1'b1;
        write_en  = wr;
        req_addr  = addr;
        req_Wdata = data;
        while (!req_ready && n < 20) begin
            step();
            n++;
        end
        check("hs_ready", req_ready, 1);
        step();
        req_valid = 1'b0;
        // Scramble request inputs: the captured copy must be used.
        req_addr  = $urandom;
        req_Wdata = {$urandom, $urandom, $urandom, $urandom};
        write_en  = $urandom_range(0, 1);
    endtask

    task automatic write_resp(logic [31:0] addr, logic [127:0] data);
        for (int k = 1; k <= int'(WR); k++) begin
            step();
            check("wr_busy", req_ready, 0);
            if (k < int'(WR)) check("wdone_early", axi_Wdone, 2'b00);
            else              check("wdone_pulse", axi_Wdone, 2'b01);
        end
        step();
        check("wdone_one_cycle", axi_Wdone, 2'b00);
        check("wr_back_idle", req_ready, 1);
        model_mem[line_of(addr)] = data;
        written[line_of(addr)]   = 1'b1;
    endtask

    task automatic read_resp(logic [127:0] exp, int unsigned hold);
        for (int k = 1; k <= int'(RD); k++) begin
            res_ready = $urandom_range(0, 1);  // no effect outside RD_RESP
            step();
            check("rd_busy", req_ready, 0);
            if (k < int'(RD)) check("rvalid_early", res_valid, 0);
        end
        check("rvalid_on_time", res_valid, 1);
        check("rdata", res_Rdata, exp);
        res_ready = (hold == 0);
        for (int h = 0; h < int'(hold); h++) begin
            step();
            check("rvalid_held", res_valid, 1);
            check("rdata_held", res_Rdata, exp);
            check("rd_hold_busy", req_ready, 0);
            if (h == int'(hold) - 1) res_ready = 1'b1;
        end
        step();
        res_ready = 1'b0;
        check("rvalid_drop", res_valid, 0);
        check("rd_back_idle", req_ready, 1);
        check("rdata_kept", res_Rdata, exp);
    endtask

    task automatic do_write(logic [31:0] addr, logic [127:0] data);
        handshake(1'b1, addr, data);
        write_resp(addr, data);
    endtask

    task automatic do_read(logic [31:0] addr, logic [127:0] exp, int unsigned hold);
        handshake(1'b0, addr, '0);
        read_resp(exp, hold);
    endtask

    initial begin
        vecs.push_back('{1'b1, 32'h0000_0120, DB, 0});
        vecs.push_back('{1'b0, 32'h0000_0120, DB, 0});
        vecs.push_back('{1'b0, 32'h0000_0120, DB, 5});
        vecs.push_back('{1'b1, 32'h0000_0010, 128'hA5A5_0000_1111_2222_3333_4444_5555_6666, 0});
        vecs.push_back('{1'b0, 32'h0000_1010, 128'hA5A5_0000_1111_2222_3333_4444_5555_6666, 1});
        vecs.push_back('{1'b1, 32'h0000_0FF0, 128'h0F0F_F0F0_1234_5678_9ABC_DEF0_CAFE_F00D, 0});
        vecs.push_back('{1'b0, 32'hF000_0FFC, 128'h0F0F_F0F0_1234_5678_9ABC_DEF0_CAFE_F00D, 2});
        vecs.push_back('{1'b0, 32'h0000_012F, DB, 0});
        vecs.push_back('{1'b1, 32'h0000_0120, 128'h1, 0});
        vecs.push_back('{1'b0, 32'h0001_0120, 128'h1, 0});

        // Reset state, with req_valid asserted and ignored.
        req_valid = 1'b1;
        write_en  = 1'b0;
        repeat (3) step();
        req_valid = 1'b0;
        check("rst_req_ready", req_ready, 1);
        check("rst_res_valid", res_valid, 0);
        check("rst_wdone", axi_Wdone, 2'b00);
        check("rst_rdata", res_Rdata, '0);
        rst = 1'b0;
        step();
        check("post_rst_idle", req_ready, 1);

        // Table-driven directed vectors.
        foreach (vecs[i]) begin
            if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].data);
            else            do_read(vecs[i].addr, vecs[i].data, vecs[i].hold);
        end

        // Read held in req_valid right behind a write handshake.
        handshake(1'b1, 32'h0000_0200, 128'h7777_8888);
        req_valid = 1'b1;
        write_en  = 1'b0;
        req_addr  = 32'h0000_0200;
        for (int k = 1; k <= int'(WR); k++) begin
            step();
            check("b2b_blocked", req_ready, 0);
            check("b2b_wdone", axi_Wdone, (k == int'(WR)) ? 2'b01 : 2'b00);
        end
        step();
        check("b2b_ready_after", req_ready, 1);
        check("b2b_wdone_clear", axi_Wdone, 2'b00);
        step();
        req_valid = 1'b0;
        model_mem[line_of(32'h200)] = 128'h7777_8888;
        written[line_of(32'h200)]   = 1'b1;
        read_resp(128'h7777_8888, 0);

        // Reset during WR_WAIT: the write is dropped.
        do_write(32'h0000_0300, 128'h5);
        handshake(1'b1, 32'h0000_0300, 128'h1);
        step();
        rst       = 1'b1;
        req_valid = 1'b1;
        write_en  = 1'b1;
        req_addr  = 32'h0000_0300;
        req_Wdata = 128'h1;
        repeat (2) begin
            step();
            check("rst_wr_no_pulse", axi_Wdone, 2'b00);
        end
        rst       = 1'b0;
        req_valid = 1'b0;
        repeat (WR + 2) begin
            step();
            check("rst_wr_no_late_pulse", axi_Wdone, 2'b00);
            check("rst_wr_idle", req_ready, 1);
        end
        do_read(32'h0000_0300, 128'h5, 0);

        // Reset during RD_RESP.
        handshake(1'b0, 32'h0000_0120, '0);
        res_ready = 1'b0;
        repeat (RD) step();
        check("rdresp_before_rst", res_valid, 1);
        rst = 1'b1;
        step();
        check("rst_rd_valid", res_valid, 0);
        check("rst_rd_data", res_Rdata, '0);
        check("rst_rd_ready", req_ready, 1);
        rst = 1'b0;
        step();

        // Randomised traffic against the array model.
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            int unsigned l;
            a       = $urandom;
            a[11:4] = 8'($urandom_range(0, 7));
            l       = line_of(a);
            if ($urandom_range(0, 1) == 1 || !written[l]) begin
                do_write(a, {$urandom, $urandom, $urandom, $urandom});
            end else begin
                do_read(a, model_mem[l], $urandom_range(0, 3));
            end
            repeat ($urandom_range(0, 2)) step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/line_mem_responder.md
LINE_MEM_RESPONDER -- requirements
Module: line_mem_responder

Interface
REQ-001 SHALL have parameter LINE_NUMS, default 256, number of 128-bit lines stored (power of two, >=2).
REQ-002 SHALL have parameter RD_LATENCY, default 4, cycles from read handshake to first res_valid (>=1).
REQ-003 SHALL have parameter WR_LATENCY, default 2, cycles from write handshake to the axi_Wdone pulse (>=1).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port req_valid  input  1  initiator request valid.
REQ-007 SHALL have port req_ready  output  1  responder accepts the request this cycle.
REQ-008 SHALL have port req_addr  input  32  line address; bits [3:0] ignored.
REQ-009 SHALL have port write_en  input  1  1 = line write-back, 0 = line fill read.
REQ-010 SHALL have port req_Wdata  input  128  write-back line data.
REQ-011 SHALL have port res_valid  output  1  read line data valid.
REQ-012 SHALL have port res_ready  input  1  initiator accepts read data.
REQ-013 SHALL have port res_Rdata  output  128  read line data.
REQ-014 SHALL have port axi_Wdone  output  2  write completion; 2'b01 = done, 2'b00 = idle, 2'b1x never driven.

Function
REQ-015 SHALL index storage with req_addr[4+log2(LINE_NUMS)-1:4]; higher address bits alias.
REQ-016 SHALL implement FSM states IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_DONE.
REQ-017 SHALL drive req_ready=1 only in IDLE; a handshake occurs when req_valid && req_ready at a rising edge.
REQ-018 SHALL capture req_addr, write_en and req_Wdata at the handshake and ignore all request inputs until back in IDLE.
REQ-019 SHALL, on a read handshake, load a counter with RD_LATENCY-1 and enter RD_WAIT; at 0 it enters RD_RESP, so res_valid first rises exactly RD_LATENCY cycles after the handshake edge.
REQ-020 SHALL hold res_valid=1 and res_Rdata stable in RD_RESP until res_ready=1 at an edge, then return to IDLE (req_ready=1 the following cycle).
REQ-021 SHALL return in res_Rdata the line contents as they stand at the handshake, including any earlier completed write.
REQ-022 SHALL, on a write handshake, load the counter with WR_LATENCY-1 and enter WR_WAIT; at 0 it enters WR_DONE.
REQ-023 SHALL in WR_DONE commit the captured 128-bit line to storage, drive axi_Wdone=2'b01 for exactly one cycle, and then return to IDLE.
REQ-024 SHALL support one outstanding transaction only; a read requested directly after a write handshake waits in req_valid until IDLE.
REQ-025 SHALL accept res_ready=1 outside RD_RESP without effect.
REQ-026 SHALL keep res_Rdata at its last value when res_valid=0.
REQ-027 SHALL not reset or initialise storage contents.

Reset
REQ-028 SHALL on rst=1 at an edge enter IDLE with req_ready=1, res_valid=0, axi_Wdone=2'b00, res_Rdata=128'h0, and counter=0.
REQ-029 SHALL discard any in-flight transaction on reset; a write not yet in WR_DONE is not committed and no axi_Wdone pulse follows.
REQ-030 SHALL ignore req_valid while rst=1.

Verification
REQ-031 SHALL pass: write addr 32'h0000_0120, data 128'hDEAD..BEEF -> axi_Wdone=2'b01 for one cycle, 2 cycles after handshake; then read 32'h0000_0120 -> res_valid 4 cycles after handshake with 128'hDEAD..BEEF.
REQ-032 SHALL pass: read with res_ready held 0 for 5 cycles after res_valid -> res_valid and res_Rdata stable all 5 cycles; req_ready=0 throughout; IDLE one cycle after res_ready=1.
REQ-033 SHALL pass: write 32'h0000_0010 (line 1) then read 32'h0000_1010 with LINE_NUMS=256 -> aliasing returns the line-1 data.
REQ-034 SHALL pass: write handshake then req_valid held with write_en=0 -> req_ready stays 0 until after the axi_Wdone pulse, read accepted the cycle after, returns the new data.
REQ-035 SHALL pass: rst=1 during WR_WAIT of a write of 128'h1 over prior 128'h5 -> no axi_Wdone pulse; a subsequent read returns 128'h5.
REQ-036 SHALL pass: rst=1 during RD_RESP -> res_valid=0, res_Rdata=0 the next cycle, req_ready=1.
